rst_merge_seq: RTL and testbench

RST_MERGE_SEQ -- requirements
Module: rst_merge_seq

---
 rtl/rst_merge_pkg.sv | 25 ++
 rtl/rst_merge_seq_sig_sync.sv | 29 ++
 rtl/rst_merge_seq.sv | 142 ++++++++++++++
 tb/tb_rst_merge_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rst_merge_pkg.sv
// Shared definitions for the reset merge / sequencer block: the sequencer
// state encoding, default parameter values and a counter-width helper.
package rst_merge_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_STRETCH = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } rst_state_e;

    localparam int DEF_SRC_NUM     = 4;
    localparam int DEF_OUT_NUM     = 3;
    localparam int DEF_STRETCH_CYC = 16;
    localparam int DEF_GAP_CYC     = 4;
    localparam int DEF_SYNC_STAGE  = 2;

    // Counter width needed to hold n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rst_merge_seq_sig_sync.sv
// Multi-bit synchroniser: each input bit gets its own STAGES-deep flop chain.
// Flops reset to 1 so that an active-low source reads as inactive during and
// right after block reset.
module sig_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [STAGES-1:0] chain;

        // Shift the raw asynchronous bit through the chain, bit 0 first.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                chain <= '1;
            end else begin
                chain <= {chain[STAGES-2:0], i_d[b]};
            end
        end

        assign o_q[b] = chain[STAGES-1];
    end

endmodule

// File: rtl/rst_merge_seq.sv
// Reset merge and sequencer. Merges several asynchronous active-low reset
// sources plus a software request into one request, holds all output resets
// asserted while any request is present, stretches for STRETCH_CYC cycles
// after the last request goes away, then releases the outputs one at a time
// in index order, GAP_CYC cycles apart. Sticky cause flags record which
// request(s) caused a reset.
module rst_merge_seq
    import rst_merge_pkg::*;
#(
    parameter int SRC_NUM     = DEF_SRC_NUM,
    parameter int OUT_NUM     = DEF_OUT_NUM,
    parameter int STRETCH_CYC = DEF_STRETCH_CYC,
    parameter int GAP_CYC     = DEF_GAP_CYC,
    parameter int SYNC_STAGE  = DEF_SYNC_STAGE,
    parameter int END_OF_LIST = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [SRC_NUM-1:0] i_src_rst_n,
    input  logic [SRC_NUM-1:0] i_src_en,
    input  logic               i_sw_rst,
    input  logic [SRC_NUM:0]   i_cause_clr,
    output logic [OUT_NUM-1:0] o_rst_n,
    output logic               o_busy,
    output logic [SRC_NUM:0]   o_cause
);

    localparam int SCW = cnt_w(STRETCH_CYC);
    localparam int GCW = cnt_w(GAP_CYC);

    localparam logic [SCW-1:0]     STRETCH_LOAD = SCW'(STRETCH_CYC - 1);
    localparam logic [GCW-1:0]     GAP_LOAD     = GCW'(GAP_CYC - 1);
    localparam logic [OUT_NUM-1:0] FIRST_BIT    = OUT_NUM'(1);

    logic [SRC_NUM-1:0] src_sync;
    logic [SRC_NUM:0]   req;
    logic               req_any;

    rst_state_e         state, state_n;
    logic [SCW-1:0]     s_cnt, s_cnt_n;
    logic [GCW-1:0]     g_cnt, g_cnt_n;
    logic [OUT_NUM-1:0] rst_n_q, rst_n_n;
    logic [OUT_NUM-1:0] rst_n_step;
    logic [SRC_NUM:0]   cause_q;

    sig_sync #(
        .WIDTH  (SRC_NUM),
        .STAGES (SYNC_STAGE)
    ) u_sig_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_src_rst_n),
        .o_q   (src_sync)
    );

    // Synchronised sources are active-low; invert, gate with enables and add
    // the software request as the top bit.
    assign req     = {i_sw_rst, ~src_sync & i_src_en};
    assign req_any = |req;

    // Released outputs always form a thermometer from bit 0 upward, so the
    // next release just shifts in another 1 at the bottom.
    assign rst_n_step = (rst_n_q << 1) | FIRST_BIT;

    // State register, counters and the registered output-reset vector.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_ASSERT;
            s_cnt   <= '0;
            g_cnt   <= '0;
            rst_n_q <= '0;
        end else begin
            state   <= state_n;
            s_cnt   <= s_cnt_n;
            g_cnt   <= g_cnt_n;
            rst_n_q <= rst_n_n;
        end
    end

    // Next-state logic: any request forces ASSERT from every state and
    // abandons in-flight counting; otherwise stretch, then release in steps.
    always_comb begin
        state_n = state;
        s_cnt_n = s_cnt;
        g_cnt_n = g_cnt;
        rst_n_n = rst_n_q;
        if (req_any) begin
            state_n = ST_ASSERT;
            s_cnt_n = '0;
            g_cnt_n = '0;
            rst_n_n = '0;
        end else begin
            case (state)
                ST_ASSERT: begin
                    state_n = ST_STRETCH;
                    s_cnt_n = STRETCH_LOAD;
                    rst_n_n = '0;
                end
                ST_STRETCH: begin
                    if (s_cnt == '0) begin
                        rst_n_n = rst_n_step;
                        g_cnt_n = GAP_LOAD;
                        state_n = (&rst_n_step) ? ST_RUN : ST_RELEASE;
                    end else begin
                        s_cnt_n = s_cnt - 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (g_cnt == '0) begin
                        rst_n_n = rst_n_step;
                        g_cnt_n = GAP_LOAD;
                        state_n = (&rst_n_step) ? ST_RUN : ST_RELEASE;
                    end else begin
                        g_cnt_n = g_cnt - 1'b1;
                    end
                end
                default: begin
                    rst_n_n = '1;
                end
            endcase
        end
    end

    // Outputs: reset vector comes straight from its register; busy until RUN.
    always_comb begin
        o_rst_n = rst_n_q;
        o_busy  = (state != ST_RUN);
    end

    // Sticky cause flags: a live request sets its flag, which beats a clear
    // strobe arriving on the same edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cause_q <= '0;
        end else begin
            cause_q <= (cause_q & ~i_cause_clr) | req;
        end
    end

    assign o_cause = cause_q;

endmodule

// File: tb/tb_rst_merge_seq.sv
// Bench for rst_merge_seq with default parameters. A driver applies directed
// and random stimulus at the falling edge and pushes the predicted outputs
// into a queue; a monitor pops and compares after every rising edge.
module tb_rst_merge_seq;

    localparam int SRC_NUM     = 4;
    localparam int OUT_NUM     = 3;
    localparam int STRETCH_CYC = 16;
    localparam int GAP_CYC     = 4;
    localparam int SYNC_STAGE  = 2;
    localparam int EW          = OUT_NUM + 1 + SRC_NUM + 1;

    logic               i_clk = 1'b0;
    logic               i_rst = 1'b1;
    logic [SRC_NUM-1:0] i_src_rst_n = '1;
    logic [SRC_NUM-1:0] i_src_en = '1;
    logic               i_sw_rst = 1'b0;
    logic [SRC_NUM:0]   i_cause_clr = '0;
    logic [OUT_NUM-1:0] o_rst_n;
    logic               o_busy;
    logic [SRC_NUM:0]   o_cause;

    always #5 i_clk = ~i_clk;

    rst_merge_seq #(
        .SRC_NUM     (SRC_NUM),
        .OUT_NUM     (OUT_NUM),
        .STRETCH_CYC (STRETCH_CYC),
        .GAP_CYC     (GAP_CYC),
        .SYNC_STAGE  (SYNC_STAGE),
        .END_OF_LIST (1)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_src_rst_n (i_src_rst_n),
        .i_src_en    (i_src_en),
        .i_sw_rst    (i_sw_rst),
        .i_cause_clr (i_cause_clr),
        .o_rst_n     (o_rst_n),
        .o_busy      (o_busy),
        .o_cause     (o_cause)
    );

    int errors = 0;
    int checks = 0;
    logic [EW-1:0] exp_q[$];
    bit started = 1'b0;
    bit done = 1'b0;
    int cyc = 0;

    // Reference model: the synchroniser is a sample delay line, and the output
    // pattern follows from how many consecutive edges have seen no request.
    int                 quiet;
    logic [SRC_NUM-1:0] src_hist[$];
    logic [SRC_NUM:0]   m_cause;

    task automatic model_reset();
        quiet = 0;
        src_hist.delete();
        for (int i = 0; i < SYNC_STAGE; i++) src_hist.push_back('1);
        m_cause = '0;
    endtask

    task automatic model_edge(input logic [SRC_NUM-1:0] src, input logic [SRC_NUM-1:0] en,
                              input logic sw, input logic [SRC_NUM:0] clr);
        logic [SRC_NUM-1:0] seen;
        logic [SRC_NUM:0]   r;
        seen = src_hist.pop_front();
        src_hist.push_back(src);
        r = {sw, ~seen & en};
        if (r != '0) quiet = 0;
        else if (quiet < 100000) quiet = quiet + 1;
        m_cause = (m_cause & ~clr) | r;
    endtask

    function automatic logic [EW-1:0] model_out();
        logic [OUT_NUM-1:0] rn;
        for (int i = 0; i < OUT_NUM; i++)
            rn[i] = (quiet >= STRETCH_CYC + 1 + i * GAP_CYC);
        return {rn, ~(&rn), m_cause};
    endfunction

    // rmode: 0 = reset low, 1 = reset held high, 2 = reset raised mid-cycle
    task automatic cycle(input logic [SRC_NUM-1:0] src, input logic [SRC_NUM-1:0] en,
                         input logic sw, input logic [SRC_NUM:0] clr, input int rmode);
        @(negedge i_clk);
        i_src_rst_n = src;
        i_src_en    = en;
        i_sw_rst    = sw;
        i_cause_clr = clr;
        if (rmode == 1) i_rst = 1'b1;
        else if (rmode == 0) i_rst = 1'b0;
        if (rmode == 2) begin
            #2;
            i_rst = 1'b1;
            #1;
            checks++;
            if (o_rst_n !== '0 || o_busy !== 1'b1 || o_cause !== '0) begin
                errors++;
                $display("FAIL async_rst: got rst_n=%b busy=%b cause=%b, need rst_n=000 busy=1 cause=00000",
                         o_rst_n, o_busy, o_cause);
            end
        end
        if (i_rst) model_reset();
        else model_edge(src, en, sw, clr);
        exp_q.push_back(model_out());
        started = 1'b1;
        cyc++;
    endtask

    // Monitor: one prediction per rising edge.
    initial begin
        logic [EW-1:0] got, exp;
        while (!done) begin
            @(posedge i_clk);
            #1;
            if (exp_q.size() == 0) begin
                if (started && !done) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got no prediction at t=%0t, need one per edge", $time);
                end
            end else begin
                exp = exp_q.pop_front();
                got = {o_rst_n, o_busy, o_cause};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL out t=%0t: got rst_n=%b busy=%b cause=%b, need rst_n=%b busy=%b cause=%b",
                             $time, got[EW-1 -: OUT_NUM], got[SRC_NUM+1], got[SRC_NUM:0],
                             exp[EW-1 -: OUT_NUM], exp[SRC_NUM+1], exp[SRC_NUM:0]);
                end
            end
        end
    end

    localparam logic [SRC_NUM-1:0] ALL1 = '1;
    localparam logic [SRC_NUM:0]   NOCLR = '0;
    localparam logic [SRC_NUM:0]   CLR_SW = 5'b10000;

    initial begin
        int lo_cnt[SRC_NUM];
        logic [SRC_NUM-1:0] src, en;
        logic sw;
        logic [SRC_NUM:0] clr;

        model_reset();
        for (int k = 0; k < SRC_NUM; k++) lo_cnt[k] = 0;

        // Held in reset, then power-up release sequence
        repeat (3) cycle(ALL1, ALL1, 1'b0, NOCLR, 1);
        repeat (32) cycle(ALL1, ALL1, 1'b0, NOCLR, 0);

        // Source 1 pulsed low in RUN, then full restart
        repeat (3) cycle(4'b1101, ALL1, 1'b0, NOCLR, 0);
        repeat (34) cycle(ALL1, ALL1, 1'b0, NOCLR, 0);
        cycle(ALL1, ALL1, 1'b0, 5'b11111, 0);

        // Disabled source 2 low: no effect
        repeat (10) cycle(4'b1011, 4'b1011, 1'b0, NOCLR, 0);
        repeat (5) cycle(ALL1, ALL1, 1'b0, NOCLR, 0);

        // Software pulse during RELEASE with a same-edge clear, then clear
        repeat (2) cycle(ALL1, ALL1, 1'b0, NOCLR, 1);
        repeat (17) cycle(ALL1, ALL1, 1'b0, NOCLR, 0);
        cycle(ALL1, ALL1, 1'b1, CLR_SW, 0);
        cycle(ALL1, ALL1, 1'b0, NOCLR, 0);
        cycle(ALL1, ALL1, 1'b0, CLR_SW, 0);
        repeat (30) cycle(ALL1, ALL1, 1'b0, NOCLR, 0);

        // Asynchronous reset mid-RELEASE, then a clean restart
        repeat (2) cycle(ALL1, ALL1, 1'b0, NOCLR, 1);
        repeat (19) cycle(ALL1, ALL1, 1'b0, NOCLR, 0);
        cycle(4'b0110, ALL1, 1'b0, NOCLR, 0);
        cycle(ALL1, ALL1, 1'b0, NOCLR, 2);
        cycle(ALL1, ALL1, 1'b0, NOCLR, 1);
        repeat (30) cycle(ALL1, ALL1, 1'b0, NOCLR, 0);

        // Random traffic with sparse source drops and software requests
        en = ALL1;
        repeat (3000) begin
            for (int k = 0; k < SRC_NUM; k++) begin
                if (lo_cnt[k] > 0) lo_cnt[k]--;
                else if ($urandom_range(0, 99) == 0) lo_cnt[k] = $urandom_range(1, 6);
                src[k] = (lo_cnt[k] == 0);
            end
            if ($urandom_range(0, 49) == 0) en = SRC_NUM'($urandom) | 4'b1001;
            sw  = ($urandom_range(0, 199) == 0);
            clr = ($urandom_range(0, 3) == 0) ? (SRC_NUM+1)'($urandom) : NOCLR;
            cycle(src, en, sw, clr, ($urandom_range(0, 999) == 0) ? 2 : 0);
            if (i_rst) cycle(src, en, 1'b0, NOCLR, 1);
        end

        @(posedge i_clk);
        #2;
        done = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d predictions left, need 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
